branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side direction/target predictor sitting beside pc_reg in the IF stage.
//  - Looks up the current fetch PC combinationally in a direct-mapped BTB with 2-bit counters.
//  - Returns predicted-taken and target to pc_reg.
//  - Takes branch resolutions from EX, raises the mispredict flush to pc_reg, trains its tables and counts perf events.
// PARAMETERS
//  IDX_W    6   BTB index width; ENTRIES = 2**IDX_W
//  TAG_W    10  tag width; tag = pc[IDX_W+TAG_W+1 : IDX_W+2]
//  CTR_INIT 2'b01  counter value at reset (weakly not-taken)
// PORTS
//  clk_i                 in   1      clock
//  rst_i                 in   1      reset: synchronous, active-high
//  if_predict_pc_i       in   RegW   fetch PC to predict (pc_reg if_predict_pc_o)
//  if_predict_taken_o    out  1      predicted taken
//  if_predict_targetPc_o out  RegW   predicted target; 0 when not taken
//  ex_br_valid_i         in   1      EX resolves a control-flow instr this cycle
//  ex_br_pc_i            in   RegW   PC of the resolved instr
//  ex_br_taken_i         in   1      actual direction
//  ex_br_target_i        in   RegW   actual target
//  ex_br_pred_taken_i    in   1      prediction carried down the pipe with the instr
//  ex_br_pred_target_i   in   RegW   predicted target carried down the pipe
//  if_predict_failed_o   out  1      mispredict; pc_reg must flush
//  if_flush_pc_o         out  RegW   correct next PC on mispredict
//  perf_br_cnt_o         out  32     resolved-branch count
//  perf_miss_cnt_o       out  32     mispredict count
// BEHAVIOUR
//  Reset:
//   - all valid bits 0; all counters CTR_INIT; tags/targets don't-care.
//   - perf counters 0.
//   - Since every entry is invalid, the combinational outputs are 0 during and right after reset.
//  Lookup (combinational, 0 latency):
//   - idx = pc[IDX_W+1:2].
//   - hit = valid[idx] && tag[idx]==pc tag.
//   - taken_o = hit && ctr[idx][1].
//   - targetPc_o = taken_o ? tgt[idx] : 0.
//  Mispredict detect (combinational from ex_* inputs):
//   - failed = ex_br_valid_i && (ex_br_taken_i != ex_br_pred_taken_i
//     || (ex_br_taken_i && ex_br_target_i != ex_br_pred_target_i)).
//   - flush_pc = ex_br_taken_i ? ex_br_target_i : ex_br_pc_i + 4
//     (add on bits [RegW-1:2]; bits [1:0] copied from ex_br_pc_i).
//   - Both outputs are 0 when failed is 0.
//  Training (posedge, only when ex_br_valid_i):
//   - Hit on ex_br_pc_i: counter saturating inc if taken, dec if not (11 max, 00 min);
//     tgt <= ex_br_target_i when taken.
//   - Miss and taken: allocate (overwrite) entry: valid=1, tag, tgt, ctr=2'b10.
//   - Miss and not taken: no table change.
//  Perf counters:
//   - br_cnt += ex_br_valid_i; miss_cnt += failed.
//   - Both wrap modulo 2**32; no saturation.
//  Boundary conditions:
//   - Lookup and training hit the same idx in one cycle: lookup returns pre-update contents (no bypass).
//   - Training visible to lookup from the next cycle.
//   - Tag alias with a different PC: treated as a hit (no full-PC compare); EX mispredict corrects it.
//   - Reset asserted mid-operation: clears as above on that edge and ignores a concurrent ex_br_valid_i.
//   - pc_reg stall (allow_nxt_pc low): outputs track the held PC; no state change from lookup.
// STRUCTURE
//  - Shared package/header (common.vh): RegW, CTR_INIT encoding, BTB entry field widths.
//  - One sub-module: btb_table.
//    - Holds valid/tag/tgt/ctr arrays.
//    - 1 async read port for lookup, 1 async read port for training.
//    - 1 sync write port.
//    - Synchronous reset of valid and ctr.
//  - Top level: compare, mispredict/flush logic, counter update, perf counters.
// TESTING
//  - Reset, then pc=0x1c000000 -> taken_o=0, targetPc_o=0, failed_o=0, perf counters 0.
//  - Resolve pc=0x1c000010, taken, target=0x1c000100, pred_taken=0 -> failed_o=1 and
//    flush_pc_o=0x1c000100 that cycle; next cycle lookup of 0x1c000010 gives taken_o=1, target 0x1c000100.
//  - Same branch resolved not-taken 2x (pred_taken=1 first) -> ctr 10->01->00; lookup taken_o=0;
//    first resolve gives failed_o=1, flush_pc_o=0x1c000014.
//  - Taken, pred_taken=1, target 0x1c000200 vs pred 0x1c000100 -> failed_o=1, flush_pc_o=0x1c000200,
//    tgt updated.
//  - Lookup and training on the same idx in one cycle -> lookup shows old entry; new entry next cycle.
//  - 10 resolves with 3 mispredicts -> br_cnt=10, miss_cnt=3; rst_i mid-stream -> all 0 and BTB empty.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   RegW          : architectural register / PC width
//   ctr_e         : 2-bit saturating direction counter encoding
//   CTR_INIT_DEF  : counter value loaded at reset (weakly not-taken)
//   CTR_ALLOC     : counter value written when a taken branch allocates
//   IDX_W_DEF     : default BTB index width
//   TAG_W_DEF     : default BTB tag width
//   ctr_next()    : saturating counter update
package branch_predictor_pkg;

  localparam int unsigned RegW      = 32;
  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned TAG_W_DEF = 10;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not-taken
    CTR_WNT = 2'b01,  // weakly not-taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  localparam logic [1:0] CTR_INIT_DEF = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC    = CTR_WT;

  // Saturating increment on taken, decrement on not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: valid / tag / target / 2-bit counter per entry.
//   clk_i, rst_i        : clock, synchronous active-high reset (valid and ctr only)
//   rd0_*               : asynchronous read port used by fetch lookup
//   rd1_*               : asynchronous read port used by EX training
//   wr_en_i, wr_*       : synchronous full-entry write port (sets valid)
// Reset has priority over a concurrent write.
module btb_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter logic [1:0]  CTR_INIT = CTR_INIT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // lookup read port
  input  logic [IDX_W-1:0] rd0_idx_i,
  output logic             rd0_valid_o,
  output logic [TAG_W-1:0] rd0_tag_o,
  output logic [RegW-1:0]  rd0_tgt_o,
  output logic [1:0]       rd0_ctr_o,
  // training read port
  input  logic [IDX_W-1:0] rd1_idx_i,
  output logic             rd1_valid_o,
  output logic [TAG_W-1:0] rd1_tag_o,
  output logic [RegW-1:0]  rd1_tgt_o,
  output logic [1:0]       rd1_ctr_o,
  // write port
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [RegW-1:0]  wr_tgt_i,
  input  logic [1:0]       wr_ctr_i
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [RegW-1:0]    tgt_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      ctr_q[wr_idx_i]   <= wr_ctr_i;
    end
  end

  // Tag and target carry no reset; they are meaningless while valid is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      tgt_q[wr_idx_i] <= wr_tgt_i;
    end
  end

  assign rd0_valid_o = valid_q[rd0_idx_i];
  assign rd0_tag_o   = tag_q[rd0_idx_i];
  assign rd0_tgt_o   = tgt_q[rd0_idx_i];
  assign rd0_ctr_o   = ctr_q[rd0_idx_i];

  assign rd1_valid_o = valid_q[rd1_idx_i];
  assign rd1_tag_o   = tag_q[rd1_idx_i];
  assign rd1_tgt_o   = tgt_q[rd1_idx_i];
  assign rd1_ctr_o   = ctr_q[rd1_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor beside pc_reg in IF.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   if_predict_pc_i        : fetch PC to look up (combinational, 0 latency)
//   if_predict_taken_o     : predicted taken
//   if_predict_targetPc_o  : predicted target, 0 when not taken
//   ex_br_*_i              : branch resolution from EX (pc, direction, target,
//                            prediction carried with the instruction)
//   if_predict_failed_o    : mispredict, pc_reg must flush
//   if_flush_pc_o          : correct next PC on mispredict, else 0
//   perf_br_cnt_o          : resolved-branch count (wraps)
//   perf_miss_cnt_o        : mispredict count (wraps)
// Lookup sees pre-update table contents; training is visible next cycle.
// Tag compare is partial, so aliases hit and are corrected by EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter logic [1:0]  CTR_INIT = CTR_INIT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [RegW-1:0] if_predict_pc_i,
  output logic            if_predict_taken_o,
  output logic [RegW-1:0] if_predict_targetPc_o,
  input  logic            ex_br_valid_i,
  input  logic [RegW-1:0] ex_br_pc_i,
  input  logic            ex_br_taken_i,
  input  logic [RegW-1:0] ex_br_target_i,
  input  logic            ex_br_pred_taken_i,
  input  logic [RegW-1:0] ex_br_pred_target_i,
  output logic            if_predict_failed_o,
  output logic [RegW-1:0] if_flush_pc_o,
  output logic [31:0]     perf_br_cnt_o,
  output logic [31:0]     perf_miss_cnt_o
);

  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = TAG_LO + TAG_W - 1;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag_rd;
  logic [RegW-1:0]  lk_tgt_rd;
  logic [1:0]       lk_ctr_rd;
  logic             lk_hit;

  // Training side
  logic [IDX_W-1:0] tr_idx;
  logic [TAG_W-1:0] tr_tag;
  logic             tr_valid;
  logic [TAG_W-1:0] tr_tag_rd;
  logic [RegW-1:0]  tr_tgt_rd;
  logic [1:0]       tr_ctr_rd;
  logic             tr_hit;

  logic             wr_en;
  logic [RegW-1:0]  wr_tgt;
  logic [1:0]       wr_ctr;

  logic             failed;
  logic [RegW-1:0]  pc_plus4;

  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic             unused_pc_bits;

  assign lk_idx = if_predict_pc_i[2 +: IDX_W];
  assign lk_tag = if_predict_pc_i[TAG_LO +: TAG_W];
  assign tr_idx = ex_br_pc_i[2 +: IDX_W];
  assign tr_tag = ex_br_pc_i[TAG_LO +: TAG_W];

  // PC bits outside index/tag do not take part in the lookup.
  assign unused_pc_bits = ^{if_predict_pc_i[RegW-1:TAG_HI+1], if_predict_pc_i[1:0]};

  btb_table #(
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd0_idx_i   (lk_idx),
    .rd0_valid_o (lk_valid),
    .rd0_tag_o   (lk_tag_rd),
    .rd0_tgt_o   (lk_tgt_rd),
    .rd0_ctr_o   (lk_ctr_rd),
    .rd1_idx_i   (tr_idx),
    .rd1_valid_o (tr_valid),
    .rd1_tag_o   (tr_tag_rd),
    .rd1_tgt_o   (tr_tgt_rd),
    .rd1_ctr_o   (tr_ctr_rd),
    .wr_en_i     (wr_en),
    .wr_idx_i    (tr_idx),
    .wr_tag_i    (tr_tag),
    .wr_tgt_i    (wr_tgt),
    .wr_ctr_i    (wr_ctr)
  );

  // Fetch lookup
  always_comb begin
    lk_hit                = lk_valid && (lk_tag_rd == lk_tag);
    if_predict_taken_o    = lk_hit && lk_ctr_rd[1];
    if_predict_targetPc_o = if_predict_taken_o ? lk_tgt_rd : '0;
  end

  // Mispredict detection and flush target; increment only on bits [RegW-1:2]
  assign pc_plus4 = {ex_br_pc_i[RegW-1:2] + (RegW-2)'(1), ex_br_pc_i[1:0]};

  always_comb begin
    failed = ex_br_valid_i &&
             ((ex_br_taken_i != ex_br_pred_taken_i) ||
              (ex_br_taken_i && (ex_br_target_i != ex_br_pred_target_i)));
    if_predict_failed_o = failed;
    if_flush_pc_o       = '0;
    if (failed) begin
      if_flush_pc_o = ex_br_taken_i ? ex_br_target_i : pc_plus4;
    end
  end

  // Training: a hit updates the counter (and target when taken); a taken
  // miss allocates. The whole entry is rewritten so a single write port suffices.
  always_comb begin
    tr_hit = tr_valid && (tr_tag_rd == tr_tag);
    wr_en  = ex_br_valid_i && (tr_hit || ex_br_taken_i);
    wr_tgt = ex_br_taken_i ? ex_br_target_i : tr_tgt_rd;
    wr_ctr = tr_hit ? ctr_next(tr_ctr_rd, ex_br_taken_i) : CTR_ALLOC;
  end

  // Perf counters
  always_comb begin
    br_cnt_d   = br_cnt_q + 32'(ex_br_valid_i);
    miss_cnt_d = miss_cnt_q + 32'(failed);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_br_cnt_o   = br_cnt_q;
  assign perf_miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_taken;
  logic [31:0] if_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        failed;
  logic [31:0] flush_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int n_pass  = 0;
  int n_total = 0;

  branch_predictor #(
    .IDX_W    (6),
    .TAG_W    (10),
    .CTR_INIT (2'b01)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .if_predict_pc_i       (if_pc),
    .if_predict_taken_o    (if_taken),
    .if_predict_targetPc_o (if_target),
    .ex_br_valid_i         (ex_valid),
    .ex_br_pc_i            (ex_pc),
    .ex_br_taken_i         (ex_taken),
    .ex_br_target_i        (ex_target),
    .ex_br_pred_taken_i    (ex_pred_taken),
    .ex_br_pred_target_i   (ex_pred_target),
    .if_predict_failed_o   (failed),
    .if_flush_pc_o         (flush_pc),
    .perf_br_cnt_o         (br_cnt),
    .perf_miss_cnt_o       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] bpc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_fail;
    logic [31:0] e_flush;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic [31:0] pc, input logic v, input logic [31:0] bpc,
                     input logic tk, input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt, input logic e_tk, input logic [31:0] e_tgt,
                     input logic e_fail, input logic [31:0] e_flush);
    vec_t x;
    x.pc = pc; x.v = v; x.bpc = bpc; x.tk = tk; x.tgt = tgt; x.ptk = ptk; x.ptgt = ptgt;
    x.e_tk = e_tk; x.e_tgt = e_tgt; x.e_fail = e_fail; x.e_flush = e_flush;
    vecs.push_back(x);
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] bpc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = bpc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  localparam logic [31:0] B    = 32'h1c000010; // idx 4, tag 0
  localparam logic [31:0] T1   = 32'h1c000100;
  localparam logic [31:0] T2   = 32'h1c000200;
  localparam logic [31:0] NONE = 32'h0;

  initial begin
    rst = 1'b1;
    if_pc = 32'h1c000000;
    drive_ex(1'b0, NONE, 1'b0, NONE, 1'b0, NONE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_taken",  {31'b0, if_taken}, 32'd0);
    check("rst_target", if_target, 32'd0);
    check("rst_failed", {31'b0, failed}, 32'd0);
    check("rst_br_cnt", br_cnt, 32'd0);
    check("rst_miss",   miss_cnt, 32'd0);

    //   lookup pc   v  ex pc        tk  target        ptk ptarget  | e_tk e_tgt  e_fail e_flush
    add(32'h1c000000, 0, NONE,        0, NONE,         0, NONE,      0, NONE, 0, NONE);
    add(B,            1, B,           1, T1,           0, NONE,      0, NONE, 1, T1);           // alloc, same-idx lookup sees old
    add(B,            1, B,           0, NONE,         1, T1,        1, T1,   1, 32'h1c000014); // 10 -> 01
    add(B,            1, B,           0, NONE,         0, NONE,      0, NONE, 0, NONE);         // 01 -> 00
    add(B,            0, NONE,        0, NONE,         0, NONE,      0, NONE, 0, NONE);
    add(B,            1, B,           1, T2,           1, T1,        0, NONE, 1, T2);           // 00 -> 01, tgt T2
    add(B,            1, B,           1, T2,           0, NONE,      0, NONE, 1, T2);           // 01 -> 10
    add(B,            0, NONE,        0, NONE,         0, NONE,      1, T2,   0, NONE);         // target updated
    add(B,            1, B,           1, T2,           1, T2,        1, T2,   0, NONE);         // 10 -> 11
    add(B,            1, B,           1, T2,           1, T2,        1, T2,   0, NONE);         // 11 saturates
    add(B,            1, B,           0, NONE,         1, T2,        1, T2,   1, 32'h1c000014); // 11 -> 10
    add(B,            0, NONE,        0, NONE,         0, NONE,      1, T2,   0, NONE);         // still taken
    add(32'h1c040010, 0, NONE,        0, NONE,         0, NONE,      1, T2,   0, NONE);         // tag alias hit
    add(32'h1c010010, 0, NONE,        0, NONE,         0, NONE,      0, NONE, 0, NONE);         // tag differs
    add(32'h1c000020, 1, 32'h1c000020, 0, NONE,        0, NONE,      0, NONE, 0, NONE);         // miss not-taken
    add(32'h1c000020, 0, NONE,        0, NONE,         0, NONE,      0, NONE, 0, NONE);         // no allocation
    add(32'h1c000000, 1, 32'h1c000032, 0, NONE,        1, T1,        0, NONE, 1, 32'h1c000036); // low bits kept
    add(32'h1c000000, 1, 32'hfffffffe, 0, NONE,        1, T1,        0, NONE, 1, 32'h00000002); // add wraps

    foreach (vecs[i]) begin
      @(negedge clk);
      if_pc = vecs[i].pc;
      drive_ex(vecs[i].v, vecs[i].bpc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      check($sformatf("v%0d_taken", i),  {31'b0, if_taken}, {31'b0, vecs[i].e_tk});
      check($sformatf("v%0d_target", i), if_target, vecs[i].e_tgt);
      check($sformatf("v%0d_failed", i), {31'b0, failed}, {31'b0, vecs[i].e_fail});
      check($sformatf("v%0d_flush", i),  flush_pc, vecs[i].e_flush);
    end
    @(negedge clk);
    drive_ex(1'b0, NONE, 1'b0, NONE, 1'b0, NONE);
    #1;
    check("tbl_br_cnt", br_cnt, 32'd11);
    check("tbl_miss",   miss_cnt, 32'd7);

    // Reset mid-stream with a concurrent taken resolve that must be ignored
    @(negedge clk);
    rst = 1'b1;
    drive_ex(1'b1, 32'h1c000040, 1'b1, T1, 1'b0, NONE);
    @(negedge clk);
    rst = 1'b0;
    drive_ex(1'b0, NONE, 1'b0, NONE, 1'b0, NONE);
    if_pc = B;
    #1;
    check("mrst_br_cnt", br_cnt, 32'd0);
    check("mrst_miss",   miss_cnt, 32'd0);
    check("mrst_taken_B", {31'b0, if_taken}, 32'd0);
    check("mrst_target_B", if_target, 32'd0);
    if_pc = 32'h1c000040;
    #1;
    check("mrst_taken_40", {31'b0, if_taken}, 32'd0);

    // 10 not-taken resolves, 3 of them predicted taken
    for (int i = 0; i < 10; i++) begin
      logic pt;
      pt = (i == 2 || i == 5 || i == 7);
      @(negedge clk);
      drive_ex(1'b1, 32'h1c000100 + 32'(4 * i), 1'b0, NONE, pt, T1);
      #1;
      check($sformatf("s%0d_failed", i), {31'b0, failed}, {31'b0, pt});
    end
    @(negedge clk);
    drive_ex(1'b0, NONE, 1'b0, NONE, 1'b0, NONE);
    #1;
    check("seq_br_cnt", br_cnt, 32'd10);
    check("seq_miss",   miss_cnt, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
